// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state type and default constants for fifo_uart_tx (macro FIFO_UART_TX_PARITY_EN)
package fifo_uart_pkg;

  // Default divider: clock cycles per serial bit.
  localparam int DEFAULT_DVSR = 16;

  // Default number of stop bits (1 or 2).
  localparam int DEFAULT_SB = 1;

  // Transmitter states; PARITY exists only when the parity build option is on.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - free-running bit-period divider with synchronous clear
module uart_baud_cnt #(
  parameter int DVSR = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DVSR);
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] count;

  // Count 0..DVSR-1; clr restarts the bit period when the transmitter changes state.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // One pulse on the final cycle of every bit period.
  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a show-ahead FIFO (macro FIFO_UART_TX_PARITY_EN adds even parity)
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int B    = 8,
  parameter int DVSR = DEFAULT_DVSR,
  parameter int SB   = DEFAULT_SB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         tx_busy
);

  localparam int IW = $clog2(B);
  localparam logic [IW-1:0] LAST_BIT  = IW'(B - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(SB - 1);

  tx_state_e     state, state_next;
  logic [B-1:0]  shift_reg, shift_next;
  logic [IW-1:0] bit_idx, bit_next;
  logic          tx_reg, tx_next;
  logic          tick;
  logic          clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par_reg, par_next;
`endif

  uart_baud_cnt #(
    .DVSR (DVSR)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Every state entry starts a fresh bit period.
  assign clr = (state_next != state);

  // Next-state, pop strobe and shift/bit-index updates; tx_next is the line level of the coming cycle.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_idx;
    fifo_rd    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    unique case (state)
      IDLE: begin
        // Reset beats a pending word so nothing is lost from the FIFO.
        if (!fifo_empty && !reset) begin
          fifo_rd    = 1'b1;
          shift_next = fifo_r_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_next   = ^fifo_r_data;
`endif
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx + IW'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // bit_idx doubles as the stop-bit counter, then returns to 0 for the next frame.
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            bit_next   = '0;
            state_next = IDLE;
          end else begin
            bit_next = bit_idx + IW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, chosen from the state being entered.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      IDLE:   tx_next = 1'b1;
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_next = par_next;
`endif
      STOP:   tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  // State, datapath and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_reg    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= bit_next;
      tx_reg    <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized self-checking bench for fifo_uart_tx with SB=1 and SB=2 instances
module tb_fifo_uart_tx;

  localparam int B    = 8;
  localparam int DVSR = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         fifo_empty  [2];
  logic [B-1:0] fifo_r_data [2];
  logic         fifo_rd     [2];
  logic         tx          [2];
  logic         tx_busy     [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.B(B), .DVSR(DVSR), .SB(1)) u_dut_sb1 (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty[0]),
    .fifo_r_data (fifo_r_data[0]),
    .fifo_rd     (fifo_rd[0]),
    .tx          (tx[0]),
    .tx_busy     (tx_busy[0])
  );

  fifo_uart_tx #(.B(B), .DVSR(DVSR), .SB(2)) u_dut_sb2 (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty[1]),
    .fifo_r_data (fifo_r_data[1]),
    .fifo_rd     (fifo_rd[1]),
    .tx          (tx[1]),
    .tx_busy     (tx_busy[1])
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           pops_model [2];
  int           pops_dut   [2];
  logic [B-1:0] fifo_q [2][$];
  bit           exp_q  [2][$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected line levels of one whole frame, one entry per clock cycle.
  task automatic load_frame(input int k, input logic [B-1:0] d);
    int sb;
    sb = (k == 0) ? 1 : 2;
    repeat (DVSR) exp_q[k].push_back(1'b0);
    for (int i = 0; i < B; i++) begin
      repeat (DVSR) exp_q[k].push_back(d[i]);
    end
`ifdef FIFO_UART_TX_PARITY_EN
    repeat (DVSR) exp_q[k].push_back(^d);
`endif
    repeat (sb * DVSR) exp_q[k].push_back(1'b1);
  endtask

  task automatic push_both(input logic [B-1:0] d);
    fifo_q[0].push_back(d);
    fifo_q[1].push_back(d);
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic rst);
    bit           busy_exp, tx_exp, rd_exp;
    logic [B-1:0] d;
    reset = rst;
    for (int k = 0; k < 2; k++) begin
      fifo_empty[k]  = (fifo_q[k].size() == 0);
      fifo_r_data[k] = (fifo_q[k].size() == 0) ? '0 : fifo_q[k][0];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      busy_exp = (exp_q[k].size() != 0);
      tx_exp   = busy_exp ? exp_q[k][0] : 1'b1;
      rd_exp   = !busy_exp && (fifo_q[k].size() != 0) && !rst;
      check_eq($sformatf("tx_sb%0d", k + 1), {31'd0, tx[k]}, {31'd0, tx_exp});
      check_eq($sformatf("tx_busy_sb%0d", k + 1), {31'd0, tx_busy[k]}, {31'd0, busy_exp});
      check_eq($sformatf("fifo_rd_sb%0d", k + 1), {31'd0, fifo_rd[k]}, {31'd0, rd_exp});
      if (fifo_rd[k] === 1'b1) pops_dut[k]++;
      if (busy_exp) void'(exp_q[k].pop_front());
      if (rst) begin
        exp_q[k].delete();
      end else if (rd_exp) begin
        d = fifo_q[k].pop_front();
        pops_model[k]++;
        load_frame(k, d);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic rst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step(rst);
    end
  endtask

  initial begin
    int left;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fifo_empty[k]  = 1'b1;
      fifo_r_data[k] = '0;
      pops_model[k]  = 0;
      pops_dut[k]    = 0;
    end
    repeat (3) @(negedge clk);

    // Reset held while a word waits: no pop until release.
    push_both(8'h11);
    run(2, 1'b1);
    run(60, 1'b0);

    // Long idle stretch with an empty FIFO.
    run(100, 1'b0);

    // Single frame, then a back-to-back pair.
    push_both(8'hA5);
    run(60, 1'b0);
    push_both(8'h00);
    push_both(8'hFF);
    run(110, 1'b0);

    // Reset ten cycles into a frame; the following word still goes out.
    push_both(8'h3C);
    push_both(8'h5A);
    run(11, 1'b0);
    run(1, 1'b1);
    run(80, 1'b0);

    // Parity corner bytes and a double-stop check byte.
    push_both(8'h07);
    push_both(8'h03);
    push_both(8'h81);
    run(160, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) push_both(B'($urandom_range(0, 255)));
      run(1, ($urandom_range(0, 499) == 0));
    end

    // Drain everything that is still queued.
    for (int i = 0; i < 6000; i++) begin
      if (fifo_q[0].size() == 0 && fifo_q[1].size() == 0 &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      run(1, 1'b0);
    end
    run(5, 1'b0);
    left = fifo_q[0].size() + fifo_q[1].size() + exp_q[0].size() + exp_q[1].size();
    check_eq("drain_left", left, 0);
    check_eq("pops_sb1", pops_dut[0], pops_model[0]);
    check_eq("pops_sb2", pops_dut[1], pops_model[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter B, default 8: data bits per frame, matching the FIFO word width.
REQ-002 SHALL have parameter DVSR, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter SB, default 1: number of stop bits, legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fifo_empty  input  1  empty flag from the FIFO read side.
REQ-007 SHALL have port fifo_r_data  input  B  FIFO head word, valid whenever fifo_empty=0 (show-ahead).
REQ-008 SHALL have port fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE, when fifo_empty=0 in cycle N: SHALL assert fifo_rd in cycle N only, capture fifo_r_data into the shift register, and enter START.
REQ-013 SHALL never assert fifo_rd while fifo_empty=1, and SHALL never assert it in any state other than IDLE.
REQ-014 tx SHALL be 0 from cycle N+1 for exactly DVSR cycles (START).
REQ-015 DATA SHALL send B bits LSB first, each held for DVSR cycles; the shift register shifts right once per bit.
REQ-016 STOP SHALL drive tx=1 for SB*DVSR cycles, then return to IDLE.
REQ-017 Back-to-back frames SHALL be separated by exactly one IDLE cycle (tx=1) between the end of STOP and the next pop.
REQ-018 The baud counter SHALL be $clog2(DVSR) bits wide, count 0..DVSR-1, and clear on every state entry.
REQ-019 The bit index SHALL be $clog2(B) bits wide and wrap to 0 on leaving DATA.
REQ-020 tx SHALL be a registered output with no combinational path from any input.
REQ-021 fifo_empty rising mid-frame SHALL have no effect on the frame already in flight.

Reset
REQ-022 On reset: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame, dropping the captured byte; no pop SHALL occur in the reset cycle.
REQ-024 When reset and fifo_empty=0 coincide, reset SHALL win and no pop SHALL occur.

Configuration
REQ-025 With macro FIFO_UART_TX_PARITY_EN defined: PARITY SHALL follow DATA, holding tx = even parity (XOR of the B data bits) for DVSR cycles.
REQ-026 With the macro undefined: PARITY and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-027 Package fifo_uart_pkg SHALL hold the state enum typedef and the default constants for DVSR and SB.
REQ-028 The divider SHALL be a sub-module, uart_baud_cnt, with ports clk, reset, clr, tick (tick pulses on count DVSR-1).

Verification (B=8, DVSR=4, SB=1)
REQ-029 Scenario: FIFO holds 0xA5 -> fifo_rd high 1 cycle; tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; the frame spans 40 cycles.
REQ-030 Scenario: FIFO holds 0x00 then 0xFF -> two frames separated by exactly one idle-high cycle, with exactly 2 fifo_rd pulses.
REQ-031 Scenario: fifo_empty held 1 for 100 cycles -> fifo_rd=0, tx=1 and tx_busy=0 throughout.
REQ-032 Scenario: reset asserted 10 cycles into the 0x3C frame -> tx=1 and state IDLE the next cycle; the next FIFO word is transmitted after release, and 0x3C is not resent.
REQ-033 Scenario: with PARITY_EN, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; the frame spans 44 cycles.
REQ-034 Scenario: with SB=2, byte 0x81 -> stop-high phase lasts 8 cycles before the next pop.
